// File: rtl/button_valid_arbiter.sv
// Debounced push-button front end sharing one valid/ready channel.
// Each press becomes one event {seq, idx}; pending requests are served round-robin.
module button_valid_arbiter #(
    parameter int NUM_BTN      = 4,
    parameter int DEBOUNCE_CYC = 4,
    parameter int DATA_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] button,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_BTN-1:0] pend,
    output logic               overflow
);
    localparam int IDX_W = $clog2(NUM_BTN);
    localparam int SEQ_W = DATA_W - IDX_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);

    logic [NUM_BTN-1:0] sync1_reg, sync2_reg;
    logic [NUM_BTN-1:0] deb, deb_prev_reg;
    logic [NUM_BTN-1:0] rise, grant;
    logic [NUM_BTN-1:0] pend_reg;
    logic [IDX_W-1:0]   last_reg, grant_idx;
    logic [SEQ_W-1:0]   seq_reg, seq_next;
    logic               found, free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            deb_prev_reg <= '0;
        end else begin
            sync1_reg    <= button;
            sync2_reg    <= sync1_reg;
            deb_prev_reg <= deb;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : gen_btn
            logic             deb_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    deb_reg <= 1'b0;
                    cnt_reg <= '0;
                end else if (sync2_reg[gi] == deb_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    deb_reg <= sync2_reg[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign deb[gi] = deb_reg;
        end
    endgenerate

    assign rise = deb & ~deb_prev_reg;
    assign free = !out_valid || out_ready;

    // Rotating search: the button after the last one served has top priority.
    always_comb begin
        int j;
        j         = 0;
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            j = (int'(last_reg) + k) % NUM_BTN;
            if (!found && pend_reg[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        if (found && free) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A grant on the accepting edge must already carry the incremented sequence.
    assign seq_next = seq_reg + SEQ_W'(out_valid && out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            pend_reg  <= '0;
            overflow  <= 1'b0;
            seq_reg   <= '0;
            last_reg  <= IDX_W'(NUM_BTN - 1);
        end else begin
            seq_reg <= seq_next;
            if (free) begin
                if (found) begin
                    out_valid <= 1'b1;
                    out_data  <= {seq_next, grant_idx};
                    last_reg  <= grant_idx;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            pend_reg <= rise | (pend_reg & ~grant);
            if (|(rise & pend_reg & ~grant)) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pend = pend_reg;
endmodule

// File: tb/tb_button_valid_arbiter.sv
// Scoreboard bench for button_valid_arbiter: expected events are queued at
// stimulus time and compared as each accepted beat leaves the channel.
module tb_button_valid_arbiter;
    localparam int NUM_BTN = 4;
    localparam int DEB     = 4;
    localparam int DATA_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_BTN-1:0] button = '0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [NUM_BTN-1:0] pend;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    button_valid_arbiter #(.NUM_BTN(NUM_BTN), .DEBOUNCE_CYC(DEB), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .button(button), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .pend(pend), .overflow(overflow)
    );

    always #2 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s value=%h t=%0t", tag, got, $time);
        end
    endtask

    // Scoreboard: one pop per accepted beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("beat", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        button = '0;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input logic [NUM_BTN-1:0] mask);
        button = button | mask;
        repeat (10) tick();
        button = button & ~mask;
        repeat (10) tick();
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 300; n++) begin
            if (exp_q.size() == 0 && !out_valid && pend == '0) break;
            tick();
        end
        if (n == 300) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [5:0] s6;
        // Reset state
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_pend", {28'd0, pend}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        do_reset();

        // 1: clean press, latency 8 edges after first sample
        exp_q.push_back(8'h00);
        button[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("lat_pre", {31'd0, out_valid}, 32'd0);
            if (k == 8) begin
                check("lat_valid", {31'd0, out_valid}, 32'd1);
                check("lat_data", {24'd0, out_data}, 32'h00);
            end
        end
        repeat (2) tick();
        button[0] = 1'b0;
        repeat (10) tick();
        wait_idle();
        check("t1_pend", {28'd0, pend}, 32'd0);

        // 2: bouncing input yields one event
        do_reset();
        exp_q.push_back(8'h01);
        for (int k = 0; k < 5; k++) begin
            button[1] = ~button[1];
            tick();
        end
        press(4'b0010);
        wait_idle();
        check("t2_ovf", {31'd0, overflow}, 32'd0);

        // 3: simultaneous presses served round-robin, then btn0 with seq 4
        do_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0F);
        press(4'b1111);
        wait_idle();
        exp_q.push_back(8'h10);
        press(4'b0001);
        wait_idle();

        // 4: stall holds data; a third press while pending overflows
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h06);
        press(4'b0100);
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {24'd0, out_data}, 32'h02);
            tick();
        end
        press(4'b0100);
        check("t4_pend2", {28'd0, pend}, 32'h4);
        check("t4_ovf0", {31'd0, overflow}, 32'd0);
        press(4'b0100);
        check("t4_ovf1", {31'd0, overflow}, 32'd1);
        check("t4_data_held", {24'd0, out_data}, 32'h02);
        out_ready = 1'b1;
        wait_idle();
        check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // 5: sequence wraps after 64 accepted beats
        do_reset();
        for (int k = 0; k < 65; k++) begin
            s6 = 6'(k);
            exp_q.push_back({s6, 2'b00});
            press(4'b0001);
        end
        wait_idle();

        // 6: async reset mid-stall, then round-robin restarts at btn 0
        do_reset();
        out_ready = 1'b0;
        press(4'b0010);
        press(4'b0010);
        press(4'b0010);
        check("t6_valid_pre", {31'd0, out_valid}, 32'd1);
        check("t6_ovf_pre", {31'd0, overflow}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_valid_rst", {31'd0, out_valid}, 32'd0);
        check("t6_pend_rst", {28'd0, pend}, 32'd0);
        check("t6_ovf_rst", {31'd0, overflow}, 32'd0);
        check("t6_data_rst", {24'd0, out_data}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h07);
        press(4'b1001);
        wait_idle();

        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
